shift_add_mult: RTL and testbench



---
 rtl/shift_add_mult_if.sv | 33 +++
 rtl/shift_add_mult.sv | 88 ++++++++
 tb/tb_shift_add_mult.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_if.sv
// Start/done handshake and operand/product bus for the shift-and-add multiplier.
interface shift_add_mult_if #(
    parameter int unsigned W = 16
) ();

    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    // Controller side: launches multiplies and collects the product.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned WxW multiplier: one W-bit add and one right shift per clock.
// A launch takes W+1 cycles to done; the {A,Q} product holds until the next launch or reset.
module shift_add_mult #(
    parameter int unsigned W = 16
) (
    input logic            clk_i,
    input logic            rst_i,
    shift_add_mult_if.slave bus
);

    localparam int unsigned CntW = $clog2(W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    m_q, m_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    q_q, q_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // W-bit add with carry-out kept as bit W, so no carry is ever lost.
    logic [W:0]      sum;

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: capture operands in idle, add/shift in run, one-cycle done.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, a_q} + {1'b0, (q_q[0] ? m_q : {W{1'b0}})};

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    m_d     = bus.a;
                    q_d     = bus.b;
                    a_d     = '0;
                    cnt_d   = CntW'(W);
                    state_d = StRun;
                end
            end
            StRun: begin
                // Sum (with carry) becomes the new upper half; Q shifts down one place.
                {a_d, q_d} = {sum, q_q[W-1:1]};
                cnt_d      = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        bus.busy    = (state_q != StIdle);
        bus.done    = (state_q == StDone);
        bus.product = {a_q, q_q};
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: a W=16 and a W=4 instance checked against a cycle-level
// arithmetic model every cycle, plus directed vectors with literal expectations.
module tb_shift_add_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned wd [2] = '{16, 4};

    logic [1:0]  rst;
    logic [1:0]  start;
    logic [15:0] a_in [2];
    logic [15:0] b_in [2];
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [31:0] product [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 16 : 4;
        shift_add_mult_if #(.W(W)) bus ();
        assign bus.start  = start[g];
        assign bus.a      = a_in[g][W-1:0];
        assign bus.b      = b_in[g][W-1:0];
        assign busy[g]    = bus.busy;
        assign done[g]    = bus.done;
        assign product[g] = 32'(bus.product);
        shift_add_mult #(.W(W)) u_dut (
            .clk_i (clk),
            .rst_i (rst[g]),
            .bus   (bus)
        );
    end

    int checks = 0;
    int passes = 0;

    // Model: k = cycles since accepted launch (0 = idle); product = a*b once done.
    int          k [2];
    logic [31:0] exp_prod [2];
    logic [31:0] pend [2];
    bit          valid [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int i, input logic [15:0] av, input logic [15:0] bv);
        start[i] = 1'b1;
        a_in[i]  = av;
        b_in[i]  = bv;
        tick();
        start[i] = 1'b0;
    endtask

    // Counts edges from the launch edge (counted as 1) until done is seen; bounded.
    task automatic wait_done(input int i, output int n);
        n = 1;
        while (!done[i] && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic mult_test(input int i, input logic [15:0] av, input logic [15:0] bv,
                             input logic [31:0] exp, input string name);
        int n;
        launch(i, av, bv);
        chk({name, "_busy"}, 32'(busy[i]), 32'd1);
        wait_done(i, n);
        chk({name, "_latency"}, n, wd[i] + 1);
        chk({name, "_product"}, product[i], exp);
        tick();
        chk({name, "_done_fall"}, 32'(done[i]), 32'd0);
        chk({name, "_hold"}, product[i], exp);
    endtask

    task automatic count_done(input int i, input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (done[i]) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        rst   = 2'b11;
        start = 2'b00;
        for (int i = 0; i < 2; i++) begin
            a_in[i]  = '0;
            b_in[i]  = '0;
            k[i]     = 0;
            exp_prod[i] = '0;
            pend[i]  = '0;
            valid[i] = 1'b0;
        end
        fork
            // Model update on every rising edge, from inputs only.
            forever begin
                @(posedge clk);
                for (int i = 0; i < 2; i++) begin
                    logic [31:0] mask;
                    mask = (32'd1 << wd[i]) - 32'd1;
                    if (rst[i]) begin
                        k[i] = 0;
                        exp_prod[i] = '0;
                        valid[i] = 1'b1;
                    end else if (k[i] == 0) begin
                        if (start[i]) begin
                            k[i] = 1;
                            pend[i] = (32'(a_in[i]) & mask) * (32'(b_in[i]) & mask);
                        end
                    end else if (k[i] == int'(wd[i]) + 1) begin
                        k[i] = 0;
                    end else begin
                        k[i]++;
                        if (k[i] == int'(wd[i]) + 1) exp_prod[i] = pend[i];
                    end
                end
            end
            // Compare process on the falling edge.
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    if (valid[i]) begin
                        chk($sformatf("model_busy%0d", i), 32'(busy[i]), 32'(k[i] != 0));
                        chk($sformatf("model_done%0d", i), 32'(done[i]),
                            32'(k[i] == int'(wd[i]) + 1));
                        if (k[i] == 0 || k[i] == int'(wd[i]) + 1)
                            chk($sformatf("model_product%0d", i), product[i], exp_prod[i]);
                    end
                end
            end
            begin
                tick();
                tick();
                rst = 2'b00;
                chk("reset_busy", 32'(busy[0]), 32'd0);
                chk("reset_done", 32'(done[0]), 32'd0);
                chk("reset_product", product[0], 32'd0);
                tick();

                mult_test(0, 16'h0003, 16'h0005, 32'h0000_000F, "m3x5");
                mult_test(0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "mffff");
                mult_test(0, 16'h1234, 16'h0000, 32'h0000_0000, "mbzero");
                mult_test(0, 16'h0000, 16'hABCD, 32'h0000_0000, "mazero");

                // Starts during RUN and during DONE must be ignored.
                launch(0, 16'h0002, 16'h0003);
                tick(); tick(); tick();
                start[0] = 1'b1; a_in[0] = 16'hFFFF; b_in[0] = 16'hFFFF;
                tick();
                start[0] = 1'b0;
                wait_done(0, n);
                chk("ign_done_seen", 32'(done[0]), 32'd1);
                start[0] = 1'b1;
                tick();
                start[0] = 1'b0;
                chk("ign_idle", 32'(busy[0]), 32'd0);
                chk("ign_product", product[0], 32'h0000_0006);
                count_done(0, 25, cnt);
                chk("ign_no_second_done", cnt, 0);
                chk("ign_product_hold", product[0], 32'h0000_0006);

                // Reset mid-run at iteration 5.
                launch(0, 16'h00FF, 16'h0101);
                tick(); tick(); tick(); tick();
                rst[0] = 1'b1;
                tick();
                rst[0] = 1'b0;
                chk("rst_busy", 32'(busy[0]), 32'd0);
                chk("rst_done", 32'(done[0]), 32'd0);
                chk("rst_product", product[0], 32'd0);
                count_done(0, 25, cnt);
                chk("rst_no_done", cnt, 0);
                mult_test(0, 16'h0007, 16'h0009, 32'h0000_003F, "m7x9");

                // W=4 instance, then start held high for a back-to-back relaunch.
                mult_test(1, 16'h000F, 16'h000F, 32'h0000_00E1, "w4");
                start[1] = 1'b1; a_in[1] = 16'h000F; b_in[1] = 16'h000F;
                tick();
                wait_done(1, n);
                chk("w4_held_latency", n, 5);
                tick();
                chk("w4_held_idle", 32'(busy[1]), 32'd0);
                tick();
                chk("w4_relaunch_busy", 32'(busy[1]), 32'd1);
                wait_done(1, n);
                chk("w4_relaunch_latency", n, 5);
                chk("w4_relaunch_product", product[1], 32'h0000_00E1);
                start[1] = 1'b0;
                tick();
                tick();
                chk("w4_end_idle", 32'(busy[1]), 32'd0);
                tick();
            end
        join_any
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
